// File: rtl/mul_arbiter.sv
// Round-robin scheduler sharing one signed fixed-point multiplier through a 2-stage pipeline.
// Define MUL_ARB_SATURATE_EN to clamp overflowing products instead of wrapping them.
module mul_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned TOTAL_BITS      = 16,
  parameter int unsigned FRACTIONAL_BITS = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*TOTAL_BITS-1:0]   req_a,
  input  logic [NUM_REQ*TOTAL_BITS-1:0]   req_b,
  output logic                            out_valid,
  output logic [$clog2(NUM_REQ)-1:0]      out_id,
  output logic [TOTAL_BITS-1:0]           out_data,
  output logic                            busy
);

  localparam int unsigned IdW   = $clog2(NUM_REQ);
  localparam int unsigned ProdW = 2 * TOTAL_BITS;

  logic [IdW-1:0]                ptr, ptr_next;
  logic                          grant_found;
  logic [IdW-1:0]                grant_id;
  logic [TOTAL_BITS-1:0]         grant_a, grant_b;
  int unsigned                   idx;

  logic                          s1_valid;
  logic [IdW-1:0]                s1_id;
  logic signed [TOTAL_BITS-1:0]  s1_a, s1_b;

  logic signed [ProdW-1:0]       prod;
  logic [TOTAL_BITS-1:0]         prod_wrap;
  logic [TOTAL_BITS-1:0]         result;

  // Scan from ptr upward (mod NUM_REQ); the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_a     = '0;
    grant_b     = '0;
    idx         = 0;
    if (reset_n) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = (32'(ptr) + k) % NUM_REQ;
        if (!grant_found && req_valid[IdW'(idx)]) begin
          grant_found = 1'b1;
          grant_id    = IdW'(idx);
          grant_a     = req_a[idx*TOTAL_BITS +: TOTAL_BITS];
          grant_b     = req_b[idx*TOTAL_BITS +: TOTAL_BITS];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    ptr_next = ptr;
    if (grant_found) begin
      ptr_next = (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + IdW'(1);
    end
  end

  assign prod      = s1_a * s1_b;
  assign prod_wrap = prod[FRACTIONAL_BITS +: TOTAL_BITS];

`ifdef MUL_ARB_SATURATE_EN
  localparam int unsigned UpW = TOTAL_BITS - FRACTIONAL_BITS + 1;

  logic [UpW-1:0] prod_upper;
  logic           unused_prod_lsb;

  // In range only if the discarded top bits plus the result sign bit are all equal.
  assign prod_upper      = prod[ProdW-1 -: UpW];
  assign unused_prod_lsb = ^prod[FRACTIONAL_BITS-1:0];

  always_comb begin
    result = prod_wrap;
    if (!(&prod_upper || ~|prod_upper)) begin
      result = prod[ProdW-1] ? {1'b1, {(TOTAL_BITS-1){1'b0}}}
                             : {1'b0, {(TOTAL_BITS-1){1'b1}}};
    end
  end
`else
  logic unused_prod_bits;

  assign unused_prod_bits = ^{prod[ProdW-1:TOTAL_BITS+FRACTIONAL_BITS],
                              prod[FRACTIONAL_BITS-1:0]};
  assign result           = prod_wrap;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
    end else begin
      ptr       <= ptr_next;
      s1_valid  <= grant_found;
      if (grant_found) begin
        s1_id <= grant_id;
        s1_a  <= grant_a;
        s1_b  <= grant_b;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_id   <= s1_id;
        out_data <= result;
      end
    end
  end

  assign busy = s1_valid | out_valid;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: queue-based model checked every cycle plus hand-computed vectors.
// Follows MUL_ARB_SATURATE_EN for overflow expectations.
module tb_mul_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int F = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic             out_valid;
  logic [1:0]       out_id;
  logic [W-1:0]     out_data;
  logic             busy;

  int total = 0;
  int bad   = 0;

  mul_arbiter #(
    .NUM_REQ         (N),
    .TOTAL_BITS      (W),
    .FRACTIONAL_BITS (F)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Exact product, floor-shifted, then wrapped or clamped to the signed output range.
  function automatic logic [W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p, r;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p >>> F;
`ifdef MUL_ARB_SATURATE_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[W-1:0];
  endfunction

  typedef struct {
    int             due;
    int             id;
    logic [W-1:0]   data;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           mptr = 0;
  int           last_id = 0;
  logic [W-1:0] last_data = '0;

  always @(negedge clk) begin
    int   g;
    exp_t e;
    cyc++;
    if (!reset_n) begin
      q.delete();
      mptr      = 0;
      last_id   = 0;
      last_data = '0;
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_id", 32'(out_id), 0);
    end else begin
      chk("m_busy", 32'(busy), (q.size() > 0) ? 1 : 0);
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("m_out_valid", 32'(out_valid), 1);
        chk("m_out_id", 32'(out_id), e.id);
        chk("m_out_data", 32'(out_data), 32'(e.data));
        last_id   = e.id;
        last_data = e.data;
      end else begin
        chk("m_out_idle", 32'(out_valid), 0);
        chk("m_hold_id", 32'(out_id), last_id);
        chk("m_hold_data", 32'(out_data), 32'(last_data));
      end
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
      end
      chk("m_ready", 32'(req_ready), (g >= 0) ? (1 << g) : 0);
      if (g >= 0) begin
        e.due  = cyc + 2;
        e.id   = g;
        e.data = model_mul(req_a[g*W +: W], req_b[g*W +: W]);
        q.push_back(e);
        mptr = (g + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset_n   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic single(input string nm, input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
    set_ops(i, a, b);
    req_valid = N'(1 << i);
    #1;
    chk({nm, "_ready"}, 32'(req_ready), 1 << i);
    tick();
    req_valid = '0;
    tick();
    chk({nm, "_valid"}, 32'(out_valid), 1);
    chk({nm, "_id"}, 32'(out_id), i);
    chk({nm, "_data"}, 32'(out_data), 32'(exp));
    tick();
    chk({nm, "_pulse_end"}, 32'(out_valid), 0);
  endtask

  localparam logic [3:0] GrantOrder [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    tick();
    tick();
    chk("init_out_valid", 32'(out_valid), 0);
    chk("init_busy", 32'(busy), 0);
    req_valid = 4'b1111;
    #1;
    chk("init_ready_in_reset", 32'(req_ready), 0);
    req_valid = '0;
    reset_n   = 1'b1;

    single("basic", 0, 16'h0180, 16'h0200, 16'h0300);
    single("signed", 2, 16'hFF00, 16'h0280, 16'hFD80);
`ifdef MUL_ARB_SATURATE_EN
    single("ovf_pos", 1, 16'h7F00, 16'h0200, 16'h7FFF);
    single("ovf_neg", 3, 16'h8000, 16'h0200, 16'h8000);
`else
    single("ovf_pos", 1, 16'h7F00, 16'h0200, 16'hFE00);
    single("ovf_neg", 3, 16'h8000, 16'h0200, 16'h0000);
`endif

    // All four requesters valid: strict rotation from index 0.
    do_reset();
    set_ops(0, 16'h0100, 16'h0300);
    set_ops(1, 16'hFE80, 16'h0140);
    set_ops(2, 16'h0333, 16'hFF40);
    set_ops(3, 16'h7FFF, 16'h0101);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 1 << GrantOrder[k]);
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Grant to 1 leaves ptr at 2, so 3 wins over 1 next.
    do_reset();
    req_valid = 4'b0010;
    #1;
    chk("ptr_first", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1010;
    #1;
    chk("ptr_skip_to3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0010;
    #1;
    chk("ptr_then1", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // One requester held valid with fresh operands each cycle.
    for (int k = 0; k < 4; k++) begin
      set_ops(2, 16'(16'h0040 * (k + 1)), 16'(16'hFF00 + k));
      req_valid = 4'b0100;
      #1;
      chk("hold_grant", 32'(req_ready), 32'h4);
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Asynchronous reset with two operations in flight.
    do_reset();
    set_ops(0, 16'h0200, 16'h0200);
    set_ops(1, 16'h0300, 16'h0100);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    chk("flight_valid", 32'(out_valid), 1);
    chk("flight_busy", 32'(busy), 1);
    req_valid = 4'b1010;
    reset_n   = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_out_id", 32'(out_id), 0);
    chk("arst_ready", 32'(req_ready), 0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("post_rst_lowest", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
